request_panel: RTL
==================

REQUEST_PANEL -- requirements
Module: request_panel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4; consecutive stable synchronized samples required before a button's debounced level changes; legal range 2..255.
REQ-002 Parameter STUCK_CYCLES, default 32; cycles a debounced press may stay high before it is flagged stuck; legal range 8..65535.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low (fixed: one clock, asynchronous active-low reset).
REQ-005 hall_btn  input  4  raw asynchronous hall-call buttons, bit i = floor i.
REQ-006 cab_btn  input  4  raw asynchronous cabin buttons, bit i = floor i.
REQ-007 current_floor  input  2  floor reported by the downstream elevator controller.
REQ-008 door_open  input  1  door state from the controller; 1 = open.
REQ-009 f_req  output  4  registered one-cycle hall request pulses to the controller.
REQ-010 c_req  output  4  registered one-cycle cabin request pulses to the controller.
REQ-011 hall_lamp  output  4  registered hall-call acknowledge lamps.
REQ-012 cab_lamp  output  4  registered cabin-call acknowledge lamps.
REQ-013 stuck  output  8  registered per-button stuck flags; [3:0] hall, [7:4] cab.

Function
REQ-014 Each of the 8 buttons SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per button, a counter SHALL increment on every edge where the synchronized level differs from the debounced level, and SHALL clear to 0 on any edge where they match.
REQ-016 The debounced level SHALL toggle, and the counter SHALL clear, on the edge where a difference is seen with counter == DEBOUNCE_CYCLES-1.
REQ-017 A raw level stable from before edge 1 SHALL change the debounced level at edge 2+DEBOUNCE_CYCLES; glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL have no effect.
REQ-018 On the edge where a debounced level rises, the matching f_req/c_req bit SHALL be set for exactly one cycle; falling edges SHALL produce no pulse.
REQ-019 A pulse SHALL be suppressed, and its lamp left unset, when door_open=1 and current_floor equals the button's floor at that edge, because the call is already served.
REQ-020 A lamp bit SHALL set on the edge its pulse is emitted and SHALL stay set until an edge with door_open=1 and current_floor equal to its floor; that clear affects both hall_lamp and cab_lamp bits.
REQ-021 If set and clear coincide for the same bit, clear SHALL win, consistent with REQ-019.
REQ-022 Per button, a hold counter SHALL count edges while the debounced level is high, saturating at STUCK_CYCLES.
REQ-023 The stuck bit SHALL set on the edge the hold counter reaches STUCK_CYCLES, and both the stuck bit and the hold counter SHALL clear on the edge the debounced level falls.
REQ-024 A stuck button SHALL generate no further pulses; its existing lamp SHALL follow REQ-020 unchanged.
REQ-025 Buttons SHALL be fully independent; simultaneous presses on any combination SHALL pulse in the same cycle.

Reset
REQ-026 While rst_n=0, the following SHALL be 0: synchronizers, debounced levels, all counters, f_req, c_req, hall_lamp, cab_lamp and stuck.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard that progress; after release, a button already held SHALL be treated as a new press, with a pulse after 2+DEBOUNCE_CYCLES edges.
REQ-028 Outputs SHALL not change on the first edge after rst_n deasserts except as REQ-017 dictates.

Structure
REQ-029 Shared package elevator_pkg SHALL hold N_FLOORS=4, FLOOR_W=2 and the floor-index-to-one-hot helper; the elevator controller SHALL use the same package.
REQ-030 A sub-module btn_debounce SHALL contain the synchronizer, debounce counter, debounced level, rise detection and hold/stuck logic; request_panel SHALL instantiate 8 of them plus the lamp/pulse registers.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=32)
REQ-031 Reset, then hall_btn=4'b0100 held from before edge 1 -> f_req=4'b0100 for exactly cycle 6..7, hall_lamp[2]=1 from edge 6.
REQ-032 cab_btn[1] pulsed high for 3 cycles -> no c_req pulse, cab_lamp stays 0.
REQ-033 hall_lamp[3]=1, then door_open=1 with current_floor=3 -> hall_lamp[3]=0 at the next edge, with other lamps unchanged.
REQ-034 cab_btn[0] pressed while door_open=1 and current_floor=0 -> no c_req pulse, cab_lamp[0] stays 0; the same press at floor 2 -> pulse and lamp set.
REQ-035 hall_btn[1] held for 50 cycles -> one pulse, stuck[1]=1 at hold count 32; on release, stuck[1]=0 four debounce cycles later.
REQ-036 rst_n low for 1 cycle mid-debounce with hall_btn[0] held -> all outputs 0; pulse appears at edge 6 after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor index width and the
// floor-index-to-one-hot helper used by the panel and the controller.
package elevator_pkg;

    localparam int N_FLOORS = 4;
    localparam int FLOOR_W  = 2;

    function automatic logic [N_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] floor);
        logic [N_FLOORS-1:0] oh;
        oh        = '0;
        oh[floor] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/request_panel_if.sv
// Button/lamp bundle between the call panel and its surroundings: the
// master side drives buttons and controller status, the slave is the panel.
interface request_panel_if;
    import elevator_pkg::*;

    logic [N_FLOORS-1:0]   hall_btn;
    logic [N_FLOORS-1:0]   cab_btn;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [N_FLOORS-1:0]   f_req;
    logic [N_FLOORS-1:0]   c_req;
    logic [N_FLOORS-1:0]   hall_lamp;
    logic [N_FLOORS-1:0]   cab_lamp;
    logic [2*N_FLOORS-1:0] stuck;

    modport master (
        output hall_btn, cab_btn, current_floor, door_open,
        input  f_req, c_req, hall_lamp, cab_lamp, stuck
    );

    modport slave (
        input  hall_btn, cab_btn, current_floor, door_open,
        output f_req, c_req, hall_lamp, cab_lamp, stuck
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, debounce counter and level, rising-edge
// strobe (combinational, aligned with the level toggle) and stuck detection.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise,
    output logic stuck
);

    localparam int CNT_W  = 8;
    localparam int HOLD_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);

    logic              sync_p0;
    logic              sync_p1;
    logic              level;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;
    logic              differ;
    logic              toggle;

    assign differ = sync_p1 ^ level;
    assign toggle = differ && (cnt == CNT_LAST);
    assign rise   = toggle && !level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            hold    <= '0;
            stuck   <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;

            if (!differ || toggle) cnt <= '0;
            else                   cnt <= cnt + 1'b1;

            if (toggle) level <= ~level;

            // Hold time is measured from the rise; release wipes it.
            if (toggle && level) begin
                hold  <= '0;
                stuck <= 1'b0;
            end else if (level && (hold != HOLD_MAX)) begin
                hold <= hold + 1'b1;
                if (hold == HOLD_MAX - 1'b1) stuck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_panel.sv
// Call panel: debounces 4 hall + 4 cabin buttons, emits one-cycle request
// pulses and keeps acknowledge lamps until the car serves that floor.
module request_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    request_panel_if.slave bus
);
    import elevator_pkg::*;

    localparam int N_BTN = 2 * N_FLOORS;

    logic [N_BTN-1:0]    raw;
    logic [N_BTN-1:0]    rise;
    logic [N_BTN-1:0]    stuck_w;
    logic [N_FLOORS-1:0] served;
    logic [N_FLOORS-1:0] hall_set;
    logic [N_FLOORS-1:0] cab_set;

    assign raw = {bus.cab_btn, bus.hall_btn};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(raw[i]),
            .rise   (rise[i]),
            .stuck  (stuck_w[i])
        );
    end

    // A call at the floor where the door is already open is served on the spot.
    assign served   = bus.door_open ? floor_onehot(bus.current_floor) : '0;
    assign hall_set = rise[N_FLOORS-1:0]     & ~stuck_w[N_FLOORS-1:0]     & ~served;
    assign cab_set  = rise[N_BTN-1:N_FLOORS] & ~stuck_w[N_BTN-1:N_FLOORS] & ~served;

    assign bus.stuck = stuck_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.f_req     <= '0;
            bus.c_req     <= '0;
            bus.hall_lamp <= '0;
            bus.cab_lamp  <= '0;
        end else begin
            bus.f_req     <= hall_set;
            bus.c_req     <= cab_set;
            bus.hall_lamp <= (bus.hall_lamp | hall_set) & ~served;
            bus.cab_lamp  <= (bus.cab_lamp  | cab_set)  & ~served;
        end
    end

endmodule
